// File: rtl/trace_capture_buffer.sv
// Instruction-trace capture buffer.
// Records one entry per retired instruction into a circular buffer. After a
// PC-match or external trigger, a programmable number of further entries is
// captured and then the buffer freezes for random-access readout. Readout
// index 0 always refers to the oldest entry still held.
module trace_capture_buffer #(
    parameter int DBITS               = 32,
    parameter int INST_BIT_WIDTH      = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int DEPTH_LOG2          = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           arm,
    input  logic                           retire,
    input  logic [DBITS-1:0]               pc_in,
    input  logic [INST_BIT_WIDTH-1:0]      inst_in,
    input  logic                           wb_en,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_idx,
    input  logic [DBITS-1:0]               wb_data,
    input  logic                           trig_en,
    input  logic [DBITS-1:0]               trig_pc,
    input  logic                           trig_ext,
    input  logic [DEPTH_LOG2-1:0]          post_count,
    input  logic                           rd_req,
    input  logic [DEPTH_LOG2-1:0]          rd_idx,
    output logic                           rd_valid,
    output logic [DBITS-1:0]               rd_pc,
    output logic [INST_BIT_WIDTH-1:0]      rd_inst,
    output logic                           rd_wb_en,
    output logic [REG_INDEX_BIT_WIDTH-1:0] rd_wb_idx,
    output logic [DBITS-1:0]               rd_wb_data,
    output logic [1:0]                     state,
    output logic [DEPTH_LOG2:0]            count,
    output logic [DEPTH_LOG2-1:0]          trig_pos
);

    localparam int                  DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] POST   = 2'd2;
    localparam logic [1:0] FROZEN = 2'd3;

    // Entry storage; deliberately not reset, count gates visibility.
    logic [DBITS-1:0]               pc_mem    [DEPTH];
    logic [INST_BIT_WIDTH-1:0]      inst_mem  [DEPTH];
    logic                           wb_en_mem [DEPTH];
    logic [REG_INDEX_BIT_WIDTH-1:0] wb_idx_mem[DEPTH];
    logic [DBITS-1:0]               wb_dat_mem[DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] trig_slot;
    logic [DEPTH_LOG2-1:0] post_left;
    logic [1:0]            state_nxt;

    logic                  do_write;
    logic                  trig_hit;
    logic                  rd_fire;
    logic                  rd_hit;
    logic [DEPTH_LOG2-1:0] wr_ptr_nxt;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic [DEPTH_LOG2-1:0] slot_nxt;
    logic [DEPTH_LOG2-1:0] oldest;
    logic [DEPTH_LOG2-1:0] oldest_nxt;
    logic [DEPTH_LOG2-1:0] rd_slot;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: arm overrides everything, then trigger / post countdown.
    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    if (trig_hit) begin
                        state_nxt = (post_count == '0) ? FROZEN : POST;
                    end
                end
                POST: begin
                    if (do_write && post_left == DEPTH_LOG2'(1)) begin
                        state_nxt = FROZEN;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Control decode: write/trigger qualification and pointer arithmetic.
    always_comb begin
        do_write   = retire && !arm && (state == ARMED || state == POST);
        trig_hit   = do_write && (state == ARMED)
                     && (trig_ext || (trig_en && pc_in == trig_pc));
        wr_ptr_nxt = do_write ? wr_ptr + 1'b1 : wr_ptr;
        count_nxt  = (do_write && count != FULL) ? count + 1'b1 : count;
        slot_nxt   = trig_hit ? wr_ptr : trig_slot;
        // Once the buffer has wrapped, the oldest entry sits at the write pointer.
        oldest     = (count == FULL) ? wr_ptr : '0;
        oldest_nxt = (count_nxt == FULL) ? wr_ptr_nxt : '0;
        rd_slot    = oldest + rd_idx;
        rd_hit     = {1'b0, rd_idx} < count;
        rd_fire    = rd_req && (state == FROZEN);
    end

    // Capture bookkeeping: pointer, fill level, trigger slot, post countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            count     <= '0;
            trig_slot <= '0;
            post_left <= '0;
            trig_pos  <= '0;
        end else if (arm) begin
            wr_ptr    <= '0;
            count     <= '0;
            trig_slot <= '0;
            post_left <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            count     <= count_nxt;
            trig_slot <= slot_nxt;
            if (trig_hit) begin
                post_left <= post_count;
            end else if (do_write && state == POST) begin
                post_left <= post_left - 1'b1;
            end
            // Trigger position is fixed relative to the final oldest entry.
            if (state_nxt == FROZEN && state != FROZEN) begin
                trig_pos <= slot_nxt - oldest_nxt;
            end
        end
    end

    // Entry write port.
    always_ff @(posedge clk) begin
        if (do_write) begin
            pc_mem[wr_ptr]     <= pc_in;
            inst_mem[wr_ptr]   <= inst_in;
            wb_en_mem[wr_ptr]  <= wb_en;
            wb_idx_mem[wr_ptr] <= wb_idx;
            wb_dat_mem[wr_ptr] <= wb_data;
        end
    end

    // Registered readout; out-of-range indices return an all-zero entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid   <= 1'b0;
            rd_pc      <= '0;
            rd_inst    <= '0;
            rd_wb_en   <= 1'b0;
            rd_wb_idx  <= '0;
            rd_wb_data <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                if (rd_hit) begin
                    rd_pc      <= pc_mem[rd_slot];
                    rd_inst    <= inst_mem[rd_slot];
                    rd_wb_en   <= wb_en_mem[rd_slot];
                    rd_wb_idx  <= wb_idx_mem[rd_slot];
                    rd_wb_data <= wb_dat_mem[rd_slot];
                end else begin
                    rd_pc      <= '0;
                    rd_inst    <= '0;
                    rd_wb_en   <= 1'b0;
                    rd_wb_idx  <= '0;
                    rd_wb_data <= '0;
                end
            end
        end
    end

endmodule
